// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller and CP0: cause codes,
// MEM exception flag positions and Status/Cause field locations.
package exc_ctrl_pkg;

  localparam logic [4:0] EC_INT  = 5'h00;
  localparam logic [4:0] EC_ADEL = 5'h04;
  localparam logic [4:0] EC_ADES = 5'h05;
  localparam logic [4:0] EC_SYS  = 5'h08;
  localparam logic [4:0] EC_BP   = 5'h09;
  localparam logic [4:0] EC_RI   = 5'h0A;
  localparam logic [4:0] EC_OV   = 5'h0C;
  localparam logic [4:0] EC_ERET = 5'h0E;
  localparam logic [4:0] EC_NONE = 5'h10;

  localparam int EXC_ADEL_IF = 0;
  localparam int EXC_RI      = 1;
  localparam int EXC_OV      = 2;
  localparam int EXC_SYS     = 3;
  localparam int EXC_BP      = 4;
  localparam int EXC_ERET    = 5;
  localparam int EXC_ADEL_LD = 6;
  localparam int EXC_ADES_ST = 7;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int IM_LO  = 8;
  localparam int IM_HI  = 15;
  localparam int IP_LO  = 8;
  localparam int IP_HI  = 15;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMMIT,
    S_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    BVA_ZERO,
    BVA_PC,
    BVA_ADDR
  } bva_sel_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority selection of one event among the interrupt and the eight
// MEM exception flags; yields the cause code and the BadVAddr source.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic       int_req,
  input  logic [7:0] exc_flags,
  output logic       hit,
  output logic [4:0] code,
  output bva_sel_e   bva_sel,
  output logic       is_eret
);

  always_comb begin
    hit     = 1'b1;
    code    = EC_NONE;
    bva_sel = BVA_ZERO;
    is_eret = 1'b0;
    if (int_req) begin
      code = EC_INT;
    end else if (exc_flags[EXC_ADEL_IF]) begin
      code    = EC_ADEL;
      bva_sel = BVA_PC;
    end else if (exc_flags[EXC_RI]) begin
      code = EC_RI;
    end else if (exc_flags[EXC_OV]) begin
      code = EC_OV;
    end else if (exc_flags[EXC_SYS]) begin
      code = EC_SYS;
    end else if (exc_flags[EXC_BP]) begin
      code = EC_BP;
    end else if (exc_flags[EXC_ERET]) begin
      code    = EC_ERET;
      is_eret = 1'b1;
    end else if (exc_flags[EXC_ADEL_LD]) begin
      code    = EC_ADEL;
      bva_sel = BVA_ADDR;
    end else if (exc_flags[EXC_ADES_ST]) begin
      code    = EC_ADES;
      bva_sel = BVA_ADDR;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller between MEM and CP0: picks one event,
// issues a one-cycle command to CP0 and then holds the pipeline flush.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        mem_stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delay_i,
  input  logic [7:0]  mem_exc_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  output logic        mem_kill_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_epc_o,
  output logic [31:0] exc_badvaddr_o,
  output logic        exc_in_delay_o,
  output logic        flush_o,
  output logic        busy_o
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;

  logic        int_req;
  logic        enc_hit;
  logic [4:0]  enc_code;
  bva_sel_e    enc_bva_sel;
  logic        enc_is_eret;
  logic        window_open;
  logic        accept;
  logic [31:0] epc_calc;
  logic [31:0] bva_calc;

  logic unused_fields;
  assign unused_fields = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  assign int_req = (|(cause_i[IP_HI:IP_LO] & status_i[IM_HI:IM_LO]))
                   & status_i[ST_IE] & ~status_i[ST_EXL];

  exc_prio_enc u_prio_enc (
    .int_req   (int_req),
    .exc_flags (mem_exc_i),
    .hit       (enc_hit),
    .code      (enc_code),
    .bva_sel   (enc_bva_sel),
    .is_eret   (enc_is_eret)
  );

  assign mem_kill_o = (state == S_IDLE) & mem_valid_i & enc_hit;

  // The last cycle of the flush window can already take the next event,
  // which gives back-to-back commits FLUSH_CYCLES edges apart.
  assign window_open = (state == S_IDLE) || (cnt == '0);
  assign accept      = window_open & mem_valid_i & ~mem_stall_i & enc_hit;

  always_comb begin
    epc_calc = mem_in_delay_i ? (mem_pc_i - 32'd4) : mem_pc_i;
    if (enc_is_eret) begin
      epc_calc = '0;
    end
    case (enc_bva_sel)
      BVA_PC:   bva_calc = mem_pc_i;
      BVA_ADDR: bva_calc = mem_addr_i;
      default:  bva_calc = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      exc_code_o     <= EC_NONE;
      exc_epc_o      <= '0;
      exc_badvaddr_o <= '0;
      exc_in_delay_o <= 1'b0;
      flush_o        <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      exc_code_o     <= EC_NONE;
      exc_epc_o      <= '0;
      exc_badvaddr_o <= '0;
      exc_in_delay_o <= 1'b0;
      if (accept) begin
        state          <= S_COMMIT;
        cnt            <= FLUSH_LOAD;
        exc_code_o     <= enc_code;
        exc_epc_o      <= epc_calc;
        exc_badvaddr_o <= bva_calc;
        exc_in_delay_o <= mem_in_delay_i & ~enc_is_eret;
        flush_o        <= 1'b1;
        busy_o         <= 1'b1;
      end else begin
        case (state)
          S_COMMIT, S_DRAIN: begin
            if (cnt == '0) begin
              state   <= S_IDLE;
              flush_o <= 1'b0;
              busy_o  <= 1'b0;
            end else begin
              state <= S_DRAIN;
              cnt   <= cnt - CNT_W'(1);
            end
          end
          default: begin
            state   <= S_IDLE;
            cnt     <= '0;
            flush_o <= 1'b0;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl with hand-computed CP0 commands.
module tb_exc_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_valid_i;
  logic        mem_stall_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delay_i;
  logic [7:0]  mem_exc_i;
  logic [31:0] mem_addr_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic        mem_kill_o;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_epc_o;
  logic [31:0] exc_badvaddr_o;
  logic        exc_in_delay_o;
  logic        flush_o;
  logic        busy_o;

  int compareCount;
  int mismatchCount;

  exc_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid_i    (mem_valid_i),
    .mem_stall_i    (mem_stall_i),
    .mem_pc_i       (mem_pc_i),
    .mem_in_delay_i (mem_in_delay_i),
    .mem_exc_i      (mem_exc_i),
    .mem_addr_i     (mem_addr_i),
    .status_i       (status_i),
    .cause_i        (cause_i),
    .mem_kill_o     (mem_kill_o),
    .exc_code_o     (exc_code_o),
    .exc_epc_o      (exc_epc_o),
    .exc_badvaddr_o (exc_badvaddr_o),
    .exc_in_delay_o (exc_in_delay_o),
    .flush_o        (flush_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic stall, input logic [31:0] pc,
                               input logic inDelay, input logic [7:0] exc,
                               input logic [31:0] addr, input logic [31:0] status,
                               input logic [31:0] cause);
    mem_valid_i    = valid;
    mem_stall_i    = stall;
    mem_pc_i       = pc;
    mem_in_delay_i = inDelay;
    mem_exc_i      = exc;
    mem_addr_i     = addr;
    status_i       = status;
    cause_i        = cause;
    #1;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCommand(input string tag, input logic [4:0] code, input logic [31:0] epc,
                              input logic [31:0] bva, input logic bd);
    checkOutput({tag, ".code"}, 32'(exc_code_o), 32'(code));
    checkOutput({tag, ".epc"}, exc_epc_o, epc);
    checkOutput({tag, ".bva"}, exc_badvaddr_o, bva);
    checkOutput({tag, ".bd"}, 32'(exc_in_delay_o), 32'(bd));
    checkOutput({tag, ".flush"}, 32'(flush_o), 32'd1);
    checkOutput({tag, ".busy"}, 32'(busy_o), 32'd1);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".code"}, 32'(exc_code_o), 32'h10);
    checkOutput({tag, ".flush"}, 32'(flush_o), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst = 1'b1;
    idleInputs();
    step();
    step();
    checkIdle("reset");
    checkOutput("reset.epc", exc_epc_o, 32'h0);
    checkOutput("reset.bva", exc_badvaddr_o, 32'h0);
    checkOutput("reset.bd", 32'(exc_in_delay_o), 32'd0);
    rst = 1'b0;
    step();
    checkIdle("postReset");

    // RI, not in a delay slot
    applyStimulus(1'b1, 1'b0, 32'hBFC00100, 1'b0, 8'h02, 32'h0, 32'h0, 32'h0);
    checkOutput("ri.kill", 32'(mem_kill_o), 32'd1);
    step();
    idleInputs();
    checkCommand("ri", 5'h0A, 32'hBFC00100, 32'h0, 1'b0);
    step();
    checkOutput("ri.code2", 32'(exc_code_o), 32'h10);
    checkOutput("ri.flush2", 32'(flush_o), 32'd1);
    checkOutput("ri.busy2", 32'(busy_o), 32'd1);
    step();
    checkIdle("ri.end");

    // AdES in a delay slot
    applyStimulus(1'b1, 1'b0, 32'h80001000, 1'b1, 8'h80, 32'h80000003, 32'h0, 32'h0);
    step();
    idleInputs();
    checkCommand("ades", 5'h05, 32'h80000FFC, 32'h80000003, 1'b1);
    step();
    step();
    checkIdle("ades.end");

    // Interrupt beats a simultaneous overflow
    applyStimulus(1'b1, 1'b0, 32'h80002000, 1'b0, 8'h04, 32'h1234, 32'h0000FF01, 32'h00000400);
    step();
    idleInputs();
    checkCommand("int", 5'h00, 32'h80002000, 32'h0, 1'b0);
    step();
    step();

    // EXL masks the interrupt; the overflow commits instead
    applyStimulus(1'b1, 1'b0, 32'h80002000, 1'b0, 8'h04, 32'h1234, 32'h0000FF03, 32'h00000400);
    step();
    idleInputs();
    checkCommand("exl.ov", 5'h0C, 32'h80002000, 32'h0, 1'b0);
    step();
    step();

    // EXL with only an interrupt pending: nothing happens
    applyStimulus(1'b1, 1'b0, 32'h80002000, 1'b0, 8'h00, 32'h0, 32'h0000FF03, 32'h00000400);
    checkOutput("exl.int.kill", 32'(mem_kill_o), 32'd0);
    step();
    idleInputs();
    checkIdle("exl.int");

    // RI outranks Ov; AdEL-fetch outranks AdEL-load
    applyStimulus(1'b1, 1'b0, 32'h80002100, 1'b0, 8'h06, 32'h0, 32'h0, 32'h0);
    step();
    idleInputs();
    checkOutput("riov.code", 32'(exc_code_o), 32'h0A);
    step();
    step();
    applyStimulus(1'b1, 1'b0, 32'h80007000, 1'b0, 8'h41, 32'h80008001, 32'h0, 32'h0);
    step();
    idleInputs();
    checkCommand("adelif", 5'h04, 32'h80007000, 32'h80007000, 1'b0);
    step();
    step();
    applyStimulus(1'b1, 1'b0, 32'h80007004, 1'b1, 8'h40, 32'h80008001, 32'h0, 32'h0);
    step();
    idleInputs();
    checkCommand("adelld", 5'h04, 32'h80007000, 32'h80008001, 1'b1);
    step();
    step();

    // ERET, then a Sys held through the flush window
    applyStimulus(1'b1, 1'b0, 32'h80003000, 1'b1, 8'h20, 32'h0, 32'h0, 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 32'h80004000, 1'b0, 8'h08, 32'h0, 32'h0, 32'h0);
    checkCommand("eret", 5'h0E, 32'h0, 32'h0, 1'b0);
    checkOutput("eret.kill", 32'(mem_kill_o), 32'd0);
    step();
    checkOutput("drain.code", 32'(exc_code_o), 32'h10);
    checkOutput("drain.flush", 32'(flush_o), 32'd1);
    step();
    idleInputs();
    checkCommand("sysAfter", 5'h08, 32'h80004000, 32'h0, 1'b0);
    step();
    step();
    checkIdle("sysAfter.end");

    // Sys under a three-cycle stall
    applyStimulus(1'b1, 1'b1, 32'h80005000, 1'b0, 8'h08, 32'h0, 32'h0, 32'h0);
    checkOutput("stall.kill", 32'(mem_kill_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkIdle("stall");
      checkOutput("stall.killHeld", 32'(mem_kill_o), 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 32'h80005000, 1'b0, 8'h08, 32'h0, 32'h0, 32'h0);
    checkIdle("stall.drop");
    step();
    idleInputs();
    checkCommand("stall.sys", 5'h08, 32'h80005000, 32'h0, 1'b0);
    step();
    step();

    // Reset asserted during the drain cycle
    applyStimulus(1'b1, 1'b0, 32'h80006000, 1'b0, 8'h10, 32'h0, 32'h0, 32'h0);
    step();
    idleInputs();
    checkCommand("bp", 5'h09, 32'h80006000, 32'h0, 1'b0);
    step();
    rst = 1'b1;
    #1;
    checkOutput("rstDrain.flushBefore", 32'(flush_o), 32'd1);
    step();
    checkIdle("rstDrain");
    rst = 1'b0;
    step();
    checkIdle("rstDrain.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt controller sitting between the MEM stage and the CP0 register block. It collects the per-instruction exception flags from MEM and samples pending interrupts against Status/Cause. It selects one event by fixed priority and issues a single-cycle exception/ERET command (code, EPC, BadVAddr, delay-slot flag) to CP0. It then holds the pipeline flush for a programmable drain window, during which further requests are ignored.

## Interface
- FLUSH_CYCLES, 2, cycles flush_o stays high after a commit (1..15)
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- mem_valid_i  in  1  valid instruction present in MEM
- mem_stall_i  in  1  MEM held (memory busy); no commit while high
- mem_pc_i  in  32  PC of the MEM instruction
- mem_in_delay_i  in  1  MEM instruction is in a branch delay slot
- mem_exc_i  in  8  flags: [0] AdEL-fetch, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] ERET, [6] AdEL-load, [7] AdES-store
- mem_addr_i  in  32  load/store effective address
- status_i  in  32  CP0 Status (IE=bit0, EXL=bit1, IM=15:8)
- cause_i  in  32  CP0 Cause (IP=15:8)
- mem_kill_o  out  1  combinational; suppress MEM side effects of current instruction
- exc_code_o  out  5  command to CP0; EC_None when idle
- exc_epc_o  out  32  EPC to record
- exc_badvaddr_o  out  32  BadVAddr to record
- exc_in_delay_o  out  1  BD flag to CP0
- flush_o  out  1  flush IF..MEM
- busy_o  out  1  state != IDLE

## Operation
- Interrupt request: int_req = |(cause_i[15:8] & status_i[15:8]) & status_i[0] & ~status_i[1].
- Event eligible in IDLE when mem_valid_i & ~mem_stall_i & (int_req | |mem_exc_i).
- Priority, high to low: Int, AdEL-fetch, RI, Ov, Sys, Bp, ERET, AdEL-load, AdES-store.
- Codes: EC_Int 5'h00, EC_AdEL 5'h04, EC_AdES 5'h05, EC_Sys 5'h08, EC_Bp 5'h09, EC_RI 5'h0A, EC_Ov 5'h0C, EC_Eret 5'h0E, EC_None 5'h10.
- EPC: mem_in_delay_i ? mem_pc_i-4 : mem_pc_i, modulo 2^32. For ERET, EPC=0 and BD=0.
- BadVAddr: AdEL-fetch gives mem_pc_i; AdEL-load and AdES-store give mem_addr_i; all others give 0.
- mem_kill_o = state==IDLE & mem_valid_i & (int_req | |mem_exc_i). It is asserted even while stalled.
- FSM states:
  - IDLE: an eligible event moves to COMMIT.
  - COMMIT: one cycle; the command outputs are valid. Moves to DRAIN, or to IDLE if FLUSH_CYCLES==1.
  - DRAIN: counts down and returns to IDLE when flush ends.
- Requests arriving in COMMIT or DRAIN are ignored. They are not queued.
- EXL set: interrupts are masked; synchronous exceptions are still committed.

## Timing
- Event accepted at edge t; exc_code_o/epc/badvaddr/in_delay are valid for exactly cycle t+1 and registered.
- flush_o is high from t+1 through t+FLUSH_CYCLES inclusive; busy_o matches flush_o.
- The first new acceptance is possible at edge t+FLUSH_CYCLES, with its command in cycle t+FLUSH_CYCLES+1.
- Stall: while mem_stall_i is high, the state stays IDLE and outputs are unchanged. Acceptance happens on the first unstalled edge with the flags present at that edge.
- Simultaneous interrupt and exception: the interrupt wins, and EPC is the MEM instruction's PC (the instruction is not executed).
- Reset values: exc_code_o=EC_None, exc_epc_o=0, exc_badvaddr_o=0, exc_in_delay_o=0, flush_o=0, busy_o=0, state IDLE, counter 0.
- Reset in COMMIT or DRAIN takes effect at the next edge and drops flush_o immediately.

## Structure
- Shared package or defines: EC_* codes, mem_exc_i bit indices, Status/Cause field positions (shared with CP0).
- Sub-module exc_prio_enc: combinational 9-input priority encoder giving code and source select. The FSM, counter and output registers stay in exc_ctrl.

## Test plan
- RI at pc 0xBFC00100, not in delay slot → cycle t+1: exc_code_o=0x0A, exc_epc_o=0xBFC00100, exc_badvaddr_o=0; flush_o high 2 cycles.
- AdES with mem_addr_i=0x80000003, mem_pc_i=0x80001000, in_delay=1 → code 0x05, epc 0x80000FFC, badvaddr 0x80000003, exc_in_delay_o=1.
- Status=0x0000FF01, Cause IP[10]=1, Ov also set → code 0x00 (Int wins), epc=mem_pc_i. Repeat with Status bit1=1 → code 0x0C.
- ERET flag → code 0x0E, epc 0; a Sys raised during DRAIN is ignored, and Sys held past DRAIN commits 0x08 at t+FLUSH_CYCLES+1.
- Sys with mem_stall_i high for 3 cycles → mem_kill_o high, no command until the cycle after stall drops.
- rst asserted in DRAIN → next cycle flush_o=0, exc_code_o=0x10, busy_o=0.
